// File: rtl/reg_error_scrubber.sv
// Error monitor and scrub sequencer for a bank of ECC-protected hash-pipeline registers.
// Counts correctable/uncorrectable events, writes back corrected data and stalls the pipeline.
module reg_error_scrubber #(
   parameter int unsigned P_NUM_REGS   = 8,
   parameter int unsigned P_CNT_WIDTH  = 8,
   parameter int unsigned P_SCRUB_WAIT = 2
) (
   input  logic                        clk,
   input  logic                        rstN,
   input  logic [P_NUM_REGS-1:0]       corr_err,
   input  logic [P_NUM_REGS-1:0]       uncorr_err,
   input  logic                        clr,
   output logic [P_NUM_REGS-1:0]       scrub_we,
   output logic                        pipe_stall,
   output logic [P_CNT_WIDTH-1:0]      corr_cnt,
   output logic [P_CNT_WIDTH-1:0]      uncorr_cnt,
   output logic [((P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1)-1:0] err_idx,
   output logic                        err_irq,
   output logic                        fatal
);

   localparam int unsigned IDX_W  = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;
   localparam int unsigned WAIT_W = (P_SCRUB_WAIT > 1) ? $clog2(P_SCRUB_WAIT) : 1;
   localparam logic [P_CNT_WIDTH-1:0] CNT_MAX  = {P_CNT_WIDTH{1'b1}};
   localparam logic [WAIT_W-1:0]      WAIT_END = WAIT_W'(P_SCRUB_WAIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCRUB = 2'd1,
      S_WAIT  = 2'd2,
      S_FATAL = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [P_NUM_REGS-1:0]   corr_q, uncorr_q;
   logic                    clr_q;
   logic [WAIT_W-1:0]       wait_q, wait_d;
   logic [P_NUM_REGS-1:0]   scrub_we_q, scrub_we_d;
   logic [P_CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
   logic [P_CNT_WIDTH-1:0]  uncorr_cnt_q, uncorr_cnt_d;
   logic [IDX_W-1:0]        err_idx_q, err_idx_d;
   logic                    err_irq_q, err_irq_d;
   logic                    fatal_q, fatal_d;
   logic                    uncorr_ev, corr_ev;
   logic [P_CNT_WIDTH-1:0]  corr_base, uncorr_base;

   // Lowest set bit of a per-register error vector.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [P_NUM_REGS-1:0] v);
      lowest_idx = '0;
      for (int i = P_NUM_REGS - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = IDX_W'(i);
      end
   endfunction

   // Input sampling stage; all decisions below use the registered copies.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         corr_q   <= '0;
         uncorr_q <= '0;
         clr_q    <= 1'b0;
      end else begin
         corr_q   <= corr_err;
         uncorr_q <= uncorr_err;
         clr_q    <= clr;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q      <= S_IDLE;
         wait_q       <= '0;
         scrub_we_q   <= '0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
         err_idx_q    <= '0;
         err_irq_q    <= 1'b0;
         fatal_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         scrub_we_q   <= scrub_we_d;
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
         err_idx_q    <= err_idx_d;
         err_irq_q    <= err_irq_d;
         fatal_q      <= fatal_d;
      end
   end

   // Next-state and status update; clr zeroes status first, then the event is applied on top.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      scrub_we_d   = '0;
      uncorr_ev    = (|uncorr_q) && (state_q != S_FATAL);
      corr_ev      = (|corr_q) && (state_q == S_IDLE) && !uncorr_ev;
      corr_base    = clr_q ? '0 : corr_cnt_q;
      uncorr_base  = clr_q ? '0 : uncorr_cnt_q;
      corr_cnt_d   = corr_base;
      uncorr_cnt_d = uncorr_base;
      err_idx_d    = clr_q ? '0 : err_idx_q;
      err_irq_d    = err_irq_q && !clr_q;

      if (uncorr_ev) begin
         if (uncorr_base != CNT_MAX) uncorr_cnt_d = uncorr_base + P_CNT_WIDTH'(1);
         err_idx_d = lowest_idx(uncorr_q);
         err_irq_d = 1'b1;
      end else if (corr_ev) begin
         if (corr_base != CNT_MAX) corr_cnt_d = corr_base + P_CNT_WIDTH'(1);
         err_idx_d = lowest_idx(corr_q);
         err_irq_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (uncorr_ev) begin
               state_d = S_FATAL;
            end else if (corr_ev) begin
               state_d    = S_SCRUB;
               scrub_we_d = corr_q;
            end
         end
         S_SCRUB: begin
            wait_d  = '0;
            state_d = uncorr_ev ? S_FATAL : S_WAIT;
         end
         S_WAIT: begin
            if (uncorr_ev) begin
               state_d = S_FATAL;
            end else if (wait_q == WAIT_END) begin
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_FATAL: begin
            if (clr_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      fatal_d = (state_d == S_FATAL);
   end

   assign scrub_we   = scrub_we_q;
   assign pipe_stall = (state_q != S_IDLE);
   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;
   assign err_idx    = err_idx_q;
   assign err_irq    = err_irq_q;
   assign fatal      = fatal_q;

endmodule
